// File: rtl/prbs8_pkg.sv
// prbs8_pkg: types and the shared LFSR recurrence for the 8-bit PRBS
// generator/checker pair.
package prbs8_pkg;

   // Checker synchronisation states.
   typedef enum logic [1:0] {
      SEED   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } chk_state_t;

   // Number of stream bits needed to fill the local history register.
   localparam int SEED_BITS = 8;

   // Next PRBS bit predicted from the last 8 bits (hist[0] newest).
   // The generator uses the identical recurrence.
   function automatic logic prbs8_next(input logic [7:0] hist,
                                       input logic [7:0] mask);
      return ^(hist & mask);
   endfunction

endpackage

// File: rtl/prbs8_sat_cnt.sv
// prbs8_sat_cnt: W-bit up counter that sticks at all-ones.
// A clear takes priority over a simultaneous increment.
module prbs8_sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: clear wins, otherwise increment unless already saturated.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/prbs8_checker.sv
// prbs8_checker: receive half of the lab BER tester. Self-synchronises a
// local 8-bit LFSR to the incoming PRBS stream, declares lock, then counts
// bit errors and drops lock when too many errors land in one window.
// Optional feature: define PRBS8_CHK_BITCNT_EN to add bit_count, the
// saturating number of valid bits observed while locked.
module prbs8_checker
   import prbs8_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int LOCK_BITS   = 16,
   parameter int WIN         = 64,
   parameter int LOSS_THRESH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       mask,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             clear,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count
`ifdef PRBS8_CHK_BITCNT_EN
   ,
   output logic [31:0]      bit_count
`endif
);

   localparam logic [3:0]  SEED_LAST = 4'(SEED_BITS - 1);
   localparam logic [7:0]  LOCK_C    = 8'(LOCK_BITS);
   localparam logic [15:0] WIN_C     = 16'(WIN);
   localparam logic [15:0] LOSS_C    = 16'(LOSS_THRESH);

   chk_state_t  state_q, state_d;
   logic [7:0]  hist_q, hist_d;
   logic [3:0]  seed_cnt_q, seed_cnt_d;
   logic [7:0]  ok_cnt_q, ok_cnt_d;
   logic [15:0] win_cnt_q, win_cnt_d;
   logic [15:0] win_err_q, win_err_d;
   logic        locked_q, locked_d;
   logic        err_pulse_q, err_pulse_d;

   logic        expected;
   logic        mismatch;
   logic        err_hit;
   logic [7:0]  shift_in;
   logic [7:0]  ok_inc;
   logic [15:0] win_cnt_inc;
   logic [15:0] win_err_inc;

   assign expected    = prbs8_next(hist_q, mask);
   assign mismatch    = (in_bit != expected);
   assign shift_in    = {hist_q[6:0], in_bit};
   assign ok_inc      = ok_cnt_q + 8'd1;
   assign win_cnt_inc = win_cnt_q + 16'd1;
   assign win_err_inc = win_err_q + {15'd0, mismatch};

   // Synchronisation FSM next-state: seed, verify, then track errors.
   always_comb begin
      state_d     = state_q;
      hist_d      = hist_q;
      seed_cnt_d  = seed_cnt_q;
      ok_cnt_d    = ok_cnt_q;
      win_cnt_d   = win_cnt_q;
      win_err_d   = win_err_q;
      locked_d    = locked_q;
      err_pulse_d = 1'b0;
      err_hit     = 1'b0;

      if (in_valid) begin
         case (state_q)
            SEED: begin
               hist_d = shift_in;
               if (seed_cnt_q == SEED_LAST) begin
                  seed_cnt_d = 4'd0;
                  // An all-zero history is the LFSR lock-up state; reseed.
                  if (shift_in != 8'd0) begin
                     state_d  = VERIFY;
                     ok_cnt_d = 8'd0;
                  end
               end else begin
                  seed_cnt_d = seed_cnt_q + 4'd1;
               end
            end

            VERIFY: begin
               hist_d = shift_in;
               if (!mismatch) begin
                  ok_cnt_d = ok_inc;
                  if (ok_inc == LOCK_C) begin
                     state_d   = LOCKED;
                     locked_d  = 1'b1;
                     win_cnt_d = 16'd0;
                     win_err_d = 16'd0;
                  end
               end else begin
                  state_d    = SEED;
                  seed_cnt_d = 4'd0;
               end
            end

            LOCKED: begin
               // Shift in the prediction so one flipped bit is one error.
               hist_d      = {hist_q[6:0], expected};
               err_hit     = mismatch;
               err_pulse_d = mismatch;
               if (win_err_inc == LOSS_C) begin
                  state_d    = SEED;
                  seed_cnt_d = 4'd0;
                  locked_d   = 1'b0;
                  win_cnt_d  = 16'd0;
                  win_err_d  = 16'd0;
               end else if (win_cnt_inc == WIN_C) begin
                  win_cnt_d = 16'd0;
                  win_err_d = 16'd0;
               end else begin
                  win_cnt_d = win_cnt_inc;
                  win_err_d = win_err_inc;
               end
            end

            default: begin
               state_d    = SEED;
               seed_cnt_d = 4'd0;
               locked_d   = 1'b0;
            end
         endcase
      end
   end

   // FSM and datapath registers, synchronous reset back to SEED.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SEED;
         hist_q      <= 8'd0;
         seed_cnt_q  <= 4'd0;
         ok_cnt_q    <= 8'd0;
         win_cnt_q   <= 16'd0;
         win_err_q   <= 16'd0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hist_q      <= hist_d;
         seed_cnt_q  <= seed_cnt_d;
         ok_cnt_q    <= ok_cnt_d;
         win_cnt_q   <= win_cnt_d;
         win_err_q   <= win_err_d;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
      end
   end

   assign locked    = locked_q;
   assign err_pulse = err_pulse_q;

   prbs8_sat_cnt #(
      .W(CNT_W)
   ) u_err_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (err_hit),
      .clr  (clear),
      .count(err_count)
   );

`ifdef PRBS8_CHK_BITCNT_EN
   logic bit_hit;
   assign bit_hit = in_valid && (state_q == LOCKED);

   prbs8_sat_cnt #(
      .W(32)
   ) u_bit_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (bit_hit),
      .clr  (clear),
      .count(bit_count)
   );
`endif

endmodule

// File: tb/tb_prbs8_checker.sv
// tb_prbs8_checker: directed test of prbs8_checker fed by a mask-B8 PRBS
// generator. A second instance with CNT_W=4 shares the stimulus to expose
// err_count saturation.
module tb_prbs8_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  mask;
   logic        in_valid;
   logic        in_bit;
   logic        clear;
   logic        locked, err_pulse;
   logic [15:0] err_count;
   logic        locked4, err_pulse4;
   logic [3:0]  err_count4;
`ifdef PRBS8_CHK_BITCNT_EN
   logic [31:0] bit_count, bit_count4;
`endif

   int          checks = 0;
   int          failures = 0;
   logic [7:0]  gen_q;
   int          pulse_cnt;
   int          drop_cnt;
   logic        watch_lock;

   always #5 clk = ~clk;

   prbs8_checker dut (
      .clk      (clk),
      .rst      (rst),
      .mask     (mask),
      .in_valid (in_valid),
      .in_bit   (in_bit),
      .clear    (clear),
      .locked   (locked),
      .err_pulse(err_pulse),
      .err_count(err_count)
`ifdef PRBS8_CHK_BITCNT_EN
      ,
      .bit_count(bit_count)
`endif
   );

   prbs8_checker #(.CNT_W(4)) dut4 (
      .clk      (clk),
      .rst      (rst),
      .mask     (mask),
      .in_valid (in_valid),
      .in_bit   (in_bit),
      .clear    (clear),
      .locked   (locked4),
      .err_pulse(err_pulse4),
      .err_count(err_count4)
`ifdef PRBS8_CHK_BITCNT_EN
      ,
      .bit_count(bit_count4)
`endif
   );

   // Single comparison point: counts and reports every check.
   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive one cycle of input and sample 1 time unit after the edge.
   task automatic applyStimulus(input logic v, input logic b);
      in_valid = v;
      in_bit   = b;
      @(posedge clk);
      #1;
      if (err_pulse) pulse_cnt++;
      if (watch_lock && !locked) drop_cnt++;
   endtask

   // Send the next generator bit, optionally inverted.
   task automatic sendGen(input logic flip);
      logic b;
      b     = ^(gen_q & 8'hB8);
      gen_q = {gen_q[6:0], b};
      applyStimulus(1'b1, b ^ flip);
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0);
      rst = 1'b0;
   endtask

   // Hard time limit so the run always ends.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int seen_lock;
      rst        = 1'b1;
      mask       = 8'hB8;
      in_valid   = 1'b0;
      in_bit     = 1'b0;
      clear      = 1'b0;
      gen_q      = 8'hFF;
      pulse_cnt  = 0;
      drop_cnt   = 0;
      watch_lock = 1'b0;

      // Reset state and clean-stream lock timing.
      doReset();
      checkOutput("rst_locked", 32'(locked), 32'd0);
      checkOutput("rst_err_pulse", 32'(err_pulse), 32'd0);
      checkOutput("rst_err_count", 32'(err_count), 32'd0);
      gen_q = 8'hFF;
      for (int i = 0; i < 23; i++) sendGen(1'b0);
      checkOutput("lock_not_at_23", 32'(locked), 32'd0);
      sendGen(1'b0);
      checkOutput("lock_at_24", 32'(locked), 32'd1);
      checkOutput("lock4_at_24", 32'(locked4), 32'd1);
      watch_lock = 1'b1; pulse_cnt = 0; drop_cnt = 0;
      for (int i = 24; i < 1000; i++) sendGen(1'b0);
      watch_lock = 1'b0;
      checkOutput("clean_err_count", 32'(err_count), 32'd0);
      checkOutput("clean_pulses", 32'(pulse_cnt), 32'd0);
      checkOutput("clean_drops", 32'(drop_cnt), 32'd0);

      // Single inverted bit at index 200.
      $display("[TB] single bit error");
      doReset();
      gen_q = 8'hFF;
      for (int i = 0; i < 24; i++) sendGen(1'b0);
      watch_lock = 1'b1; pulse_cnt = 0; drop_cnt = 0;
      for (int i = 24; i < 200; i++) sendGen(1'b0);
      sendGen(1'b1);
      checkOutput("flip_pulse", 32'(err_pulse), 32'd1);
      checkOutput("flip_count", 32'(err_count), 32'd1);
      sendGen(1'b0);
      checkOutput("flip_pulse_gone", 32'(err_pulse), 32'd0);
      for (int i = 202; i < 400; i++) sendGen(1'b0);
      watch_lock = 1'b0;
      checkOutput("flip_pulse_total", 32'(pulse_cnt), 32'd1);
      checkOutput("flip_count_end", 32'(err_count), 32'd1);
      checkOutput("flip_no_drop", 32'(drop_cnt), 32'd0);

      // Four errors within ten bits force relock.
      $display("[TB] loss of lock");
      doReset();
      gen_q = 8'hFF;
      for (int i = 0; i < 100; i++) sendGen(1'b0);
      for (int i = 100; i < 107; i++) sendGen((i % 3) == 1);
      checkOutput("loss_still_locked_3err", 32'(locked), 32'd1);
      sendGen(1'b0); sendGen(1'b0);
      sendGen(1'b1);
      checkOutput("loss_on_4th", 32'(locked), 32'd0);
      checkOutput("loss_err_count", 32'(err_count), 32'd4);
      for (int i = 0; i < 23; i++) sendGen(1'b0);
      checkOutput("relock_not_at_23", 32'(locked), 32'd0);
      sendGen(1'b0);
      checkOutput("relock_at_24", 32'(locked), 32'd1);
      checkOutput("relock_err_count", 32'(err_count), 32'd4);

      // Constant zero input never leaves SEED.
      $display("[TB] all-zero stream");
      doReset();
      seen_lock = 0;
      for (int i = 0; i < 500; i++) begin
         applyStimulus(1'b1, 1'b0);
         if (locked) seen_lock++;
      end
      checkOutput("zero_seen_lock", 32'(seen_lock), 32'd0);
      checkOutput("zero_err_count", 32'(err_count), 32'd0);

      // Twenty isolated errors: saturation in the 4-bit instance, then clear.
      $display("[TB] saturation and clear");
      doReset();
      gen_q = 8'hFF;
      for (int i = 0; i < 2050; i++)
         sendGen((i >= 100) && (i <= 2000) && ((i % 100) == 0));
      checkOutput("sat_count16", 32'(err_count), 32'd20);
      checkOutput("sat_count4", 32'(err_count4), 32'd15);
      checkOutput("sat_locked4", 32'(locked4), 32'd1);
      clear = 1'b1;
      sendGen(1'b0);
      clear = 1'b0;
      checkOutput("clear_count4", 32'(err_count4), 32'd0);
      checkOutput("clear_count16", 32'(err_count), 32'd0);
      checkOutput("clear_locked4", 32'(locked4), 32'd1);
`ifdef PRBS8_CHK_BITCNT_EN
      checkOutput("clear_bit_count", bit_count, 32'd0);
`endif
      clear = 1'b1;
      sendGen(1'b1);
      clear = 1'b0;
      checkOutput("clear_beats_err", 32'(err_count), 32'd0);
      checkOutput("clear_err_pulse", 32'(err_pulse), 32'd1);

      // Drop lock, then reset mid-VERIFY with 50% valid duty.
      $display("[TB] reset mid-verify");
      for (int i = 0; i < 70; i++) sendGen(1'b0);
      for (int i = 0; i < 4; i++) sendGen(1'b1);
      checkOutput("burst_locked", 32'(locked), 32'd0);
      checkOutput("burst_count", 32'(err_count), 32'd4);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, 1'b0);
         sendGen(1'b0);
      end
      rst = 1'b1;
      applyStimulus(1'b1, 1'b0);
      rst = 1'b0;
      checkOutput("midrst_locked", 32'(locked), 32'd0);
      checkOutput("midrst_err_pulse", 32'(err_pulse), 32'd0);
      checkOutput("midrst_count", 32'(err_count), 32'd0);
      checkOutput("midrst_count4", 32'(err_count4), 32'd0);
      for (int i = 0; i < 23; i++) begin
         applyStimulus(1'b0, 1'b0);
         sendGen(1'b0);
      end
      checkOutput("toggle_not_at_23", 32'(locked), 32'd0);
      applyStimulus(1'b0, 1'b0);
      sendGen(1'b0);
      checkOutput("toggle_lock_at_24", 32'(locked), 32'd1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("toggle_hold", 32'(locked), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
